// File: rtl/deskew_image_reader.sv
// -----------------------------------------------------------------------------
// deskew_image_reader
//
// Unloads the deskewed image from the shared image BRAM.
// The image sits at words BASE_ADDR .. BASE_ADDR+NUM_PIX-1.
// The words leave in ascending address order on a valid/ready stream.
// A 2-entry prefetch FIFO covers the 1-cycle BRAM read latency, so the block
// sustains one pixel per cycle while the sink never applies backpressure.
//
// Ports:
//   clk      system clock; all logic runs on the rising edge.
//   reset    asynchronous, active-high reset.
//   start    begins an unload; sampled only while idle.
//   ready    high while idle, meaning the block accepts start.
//   address  BRAM word address. It is 0 whenever no read is issued.
//   in_data  BRAM read data. It is valid the cycle after en=1.
//   en       BRAM read strobe.
//   we       BRAM write enable; always 0, because this block only reads.
//   m_data   stream pixel, driven from the FIFO head register.
//   m_valid  m_data is valid.
//   m_ready  downstream accepts; a beat transfers on m_valid && m_ready.
//   m_last   marks the final pixel of the frame.
// -----------------------------------------------------------------------------
module deskew_image_reader #(
  parameter int WIDTH     = 16,
  parameter int BASE_ADDR = 784,
  parameter int NUM_PIX   = 784
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic [10:0]      address,
  input  logic [WIDTH-1:0] in_data,
  output logic             en,
  output logic             we,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [10:0] BASE     = 11'(BASE_ADDR);
  localparam logic [10:0] NPIX     = 11'(NUM_PIX);
  localparam logic [10:0] LAST_IDX = 11'(NUM_PIX - 1);

  state_t           state_q, state_d;
  logic [10:0]      rd_cnt_q, rd_cnt_d;
  logic [10:0]      beat_cnt_q, beat_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;   // FIFO head; this register drives m_data
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic             last_beat;
  logic             start_run;
  logic [2:0]       committed;

  // ---------------------------------------------------------------------------
  // Shared control terms
  // ---------------------------------------------------------------------------
  always_comb begin
    start_run = (state_q == IDLE) && start;
    pop       = (occ_q != 2'd0) && m_ready;
    push      = inflight_q;
    last_beat = pop && (beat_cnt_q == LAST_IDX);
    // A word leaving this cycle frees its slot in time for a read issued now.
    // This lets reads continue at one per cycle while the sink keeps draining.
    committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == RUN) && (rd_cnt_q < NPIX) && (committed < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // State register (FSM, counters, prefetch FIFO)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    inflight_d = issue;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_run) begin
      rd_cnt_d   = '0;
      beat_cnt_d = '0;
    end else begin
      if (issue) rd_cnt_d = rd_cnt_q + 11'd1;
      if (pop) beat_cnt_d = beat_cnt_q + 11'd1;
    end

    // Two-entry FIFO. buf0 is always the oldest word. A pop shifts buf1 down.
    // A push lands in the first slot that is free after the pop.
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = in_data;
        else               buf1_d = in_data;
      end
      2'b01: begin
        buf0_d = buf1_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = in_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready   = (state_q == IDLE);
    en      = issue;
    address = issue ? (BASE + rd_cnt_q) : 11'd0;
    we      = 1'b0;
    m_valid = (occ_q != 2'd0);
    m_last  = (occ_q != 2'd0) && (beat_cnt_q == LAST_IDX);
    m_data  = buf0_q;
  end

  // The read-issue credit check guarantees that a word never arrives
  // while both slots are held and nothing is leaving.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (reset) (push && (occ_q == 2'd2)) |-> pop
  );

endmodule
